// File: rtl/maze_player_ctrl_if.sv
// Move-request and wall-lookup signals between the player controller and its
// neighbours. The controller is the slave: it takes requests and drives the lookup address.
interface maze_player_ctrl_if;
    logic       move_req;
    logic [1:0] move_dir;
    logic [5:0] map_row;
    logic [5:0] map_col;
    logic       map_wall;

    modport slave (
        input  move_req,
        input  move_dir,
        input  map_wall,
        output map_row,
        output map_col
    );

    modport master (
        output move_req,
        output move_dir,
        output map_wall,
        input  map_row,
        input  map_col
    );
endinterface

// File: rtl/maze_player_ctrl.sv
// Player position owner for the maze grid: validates one-step moves against the
// wall map, tracks key pickup / exit lock and pulses stage_clear on an unlocked exit.
module maze_player_ctrl #(
    parameter int MAP_SIZE      = 41,
    parameter int START_ROW     = 1,
    parameter int START_COL     = 1,
    parameter int KEY_ROW       = 37,
    parameter int KEY_COL       = 1,
    parameter int EXIT_COL      = 40,
    parameter int EXIT_ROW_LO   = 19,
    parameter int EXIT_ROW_HI   = 21,
    parameter int MOVE_COOLDOWN = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        state,
    maze_player_ctrl_if.slave bus,
    output logic [5:0]        player_row,
    output logic [5:0]        player_col,
    output logic              isLocked,
    output logic              key_taken,
    output logic              stage_clear,
    output logic              busy
);
    localparam int CW = (MOVE_COOLDOWN > 1) ? $clog2(MOVE_COOLDOWN) : 1;
    localparam logic signed [6:0] MAX_IDX = 7'(MAP_SIZE - 1);
    localparam logic [5:0] START_R = 6'(START_ROW);
    localparam logic [5:0] START_C = 6'(START_COL);
    localparam logic [5:0] KEY_R   = 6'(KEY_ROW);
    localparam logic [5:0] KEY_C   = 6'(KEY_COL);
    localparam logic [5:0] EXIT_C  = 6'(EXIT_COL);
    localparam logic [5:0] EXIT_LO = 6'(EXIT_ROW_LO);
    localparam logic [5:0] EXIT_HI = 6'(EXIT_ROW_HI);
    localparam logic [3:0] ACTIVE_CODES [3] = '{4'd2, 4'd4, 4'd6};

    typedef enum logic [1:0] {IDLE, QUERY, CHECK, COOLDOWN} fsm_t;

    fsm_t            fsm_reg, fsm_next;
    logic [5:0]      row_reg, row_next, col_reg, col_next;
    logic [5:0]      tgt_row_reg, tgt_row_next, tgt_col_reg, tgt_col_next;
    logic            locked_reg, locked_next, key_reg, key_next;
    logic            clear_reg, clear_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      prev_state_reg;

    logic [2:0]        active_hit;
    logic              active, stage_entry;
    logic signed [6:0] cur_row_s, cur_col_s, step_row, step_col;
    logic              in_bounds, tgt_is_exit, tgt_is_key;

    for (genvar gi = 0; gi < 3; gi++) begin : g_active
        assign active_hit[gi] = (state == ACTIVE_CODES[gi]);
    end

    assign active      = |active_hit;
    assign stage_entry = active && (state != prev_state_reg);

    // Step in 7-bit signed so that moving off row/col 0 shows up as negative.
    assign cur_row_s = signed'({1'b0, row_reg});
    assign cur_col_s = signed'({1'b0, col_reg});

    always_comb begin
        step_row = cur_row_s;
        step_col = cur_col_s;
        case (bus.move_dir)
            2'd0:    step_row = cur_row_s - 7'sd1;
            2'd1:    step_row = cur_row_s + 7'sd1;
            2'd2:    step_col = cur_col_s - 7'sd1;
            default: step_col = cur_col_s + 7'sd1;
        endcase
    end

    assign in_bounds = (step_row >= 7'sd0) && (step_row <= MAX_IDX) &&
                       (step_col >= 7'sd0) && (step_col <= MAX_IDX);
    assign tgt_is_exit = (tgt_col_reg == EXIT_C) &&
                         (tgt_row_reg >= EXIT_LO) && (tgt_row_reg <= EXIT_HI);
    assign tgt_is_key  = (tgt_row_reg == KEY_R) && (tgt_col_reg == KEY_C);

    always_comb begin
        fsm_next     = fsm_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        tgt_row_next = tgt_row_reg;
        tgt_col_next = tgt_col_reg;
        locked_next  = locked_reg;
        key_next     = key_reg;
        clear_next   = 1'b0;
        cnt_next     = cnt_reg;
        if (stage_entry) begin
            fsm_next    = IDLE;
            row_next    = START_R;
            col_next    = START_C;
            locked_next = 1'b1;
            key_next    = 1'b0;
            cnt_next    = '0;
        end else if (!active) begin
            fsm_next = IDLE;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (bus.move_req && in_bounds) begin
                        tgt_row_next = step_row[5:0];
                        tgt_col_next = step_col[5:0];
                        fsm_next     = QUERY;
                    end
                end
                QUERY: fsm_next = CHECK;
                CHECK: begin
                    // Wall bit for the target arrives now, one cycle after the address.
                    if (bus.map_wall || (tgt_is_exit && locked_reg)) begin
                        fsm_next = IDLE;
                    end else begin
                        row_next = tgt_row_reg;
                        col_next = tgt_col_reg;
                        cnt_next = CW'(MOVE_COOLDOWN - 1);
                        fsm_next = COOLDOWN;
                        if (tgt_is_key) begin
                            key_next    = 1'b1;
                            locked_next = 1'b0;
                        end
                        if (tgt_is_exit) clear_next = 1'b1;
                    end
                end
                default: begin
                    if (cnt_reg == '0) fsm_next = IDLE;
                    else               cnt_next = cnt_reg - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg        <= IDLE;
            row_reg        <= START_R;
            col_reg        <= START_C;
            tgt_row_reg    <= START_R;
            tgt_col_reg    <= START_C;
            locked_reg     <= 1'b1;
            key_reg        <= 1'b0;
            clear_reg      <= 1'b0;
            cnt_reg        <= '0;
            prev_state_reg <= 4'd0;
        end else begin
            fsm_reg        <= fsm_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            tgt_row_reg    <= tgt_row_next;
            tgt_col_reg    <= tgt_col_next;
            locked_reg     <= locked_next;
            key_reg        <= key_next;
            clear_reg      <= clear_next;
            cnt_reg        <= cnt_next;
            prev_state_reg <= state;
        end
    end

    assign bus.map_row = (fsm_reg == QUERY || fsm_reg == CHECK) ? tgt_row_reg : row_reg;
    assign bus.map_col = (fsm_reg == QUERY || fsm_reg == CHECK) ? tgt_col_reg : col_reg;
    assign player_row  = row_reg;
    assign player_col  = col_reg;
    assign isLocked    = locked_reg;
    assign key_taken   = key_reg;
    assign stage_clear = clear_reg;
    assign busy        = (fsm_reg != IDLE);
endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: three instances (default start, east-edge start,
// exit-adjacent start with nearby key) checked against directed and random-walk expectations.
module tb_maze_player_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req [3];
    logic [1:0] dir [3];
    logic [3:0] st [3];
    logic [5:0] prow [3];
    logic [5:0] pcol [3];
    logic       lock_o [3];
    logic       key_o [3];
    logic       clr_o [3];
    logic       busy_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    bit wall_a [64][64];

    maze_player_ctrl_if if_a();
    maze_player_ctrl_if if_b();
    maze_player_ctrl_if if_c();

    assign if_a.move_req = req[0];
    assign if_a.move_dir = dir[0];
    assign if_b.move_req = req[1];
    assign if_b.move_dir = dir[1];
    assign if_c.move_req = req[2];
    assign if_c.move_dir = dir[2];

    // Wall map model: registered lookup, one cycle of latency.
    always @(posedge clk) begin
        if_a.map_wall <= wall_a[if_a.map_row][if_a.map_col];
        if_b.map_wall <= 1'b0;
        if_c.map_wall <= 1'b0;
    end

    maze_player_ctrl #(.MOVE_COOLDOWN(4)) u_a (
        .clk(clk), .rst(rst), .state(st[0]), .bus(if_a),
        .player_row(prow[0]), .player_col(pcol[0]), .isLocked(lock_o[0]),
        .key_taken(key_o[0]), .stage_clear(clr_o[0]), .busy(busy_o[0]));

    maze_player_ctrl #(.START_ROW(20), .START_COL(40), .MOVE_COOLDOWN(4)) u_b (
        .clk(clk), .rst(rst), .state(st[1]), .bus(if_b),
        .player_row(prow[1]), .player_col(pcol[1]), .isLocked(lock_o[1]),
        .key_taken(key_o[1]), .stage_clear(clr_o[1]), .busy(busy_o[1]));

    maze_player_ctrl #(.START_ROW(20), .START_COL(39), .KEY_ROW(20), .KEY_COL(38),
                       .MOVE_COOLDOWN(4)) u_c (
        .clk(clk), .rst(rst), .state(st[2]), .bus(if_c),
        .player_row(prow[2]), .player_col(pcol[2]), .isLocked(lock_o[2]),
        .key_taken(key_o[2]), .stage_clear(clr_o[2]), .busy(busy_o[2]));

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request and counts busy cycles / stage_clear pulses until idle.
    task automatic do_move(input int inst, input logic [1:0] d,
                           output int busy_n, output int clear_n);
        busy_n  = 0;
        clear_n = 0;
        @(negedge clk);
        req[inst] = 1'b1;
        dir[inst] = d;
        @(negedge clk);
        req[inst] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy_o[inst] !== 1'b1) break;
            busy_n++;
            if (clr_o[inst] === 1'b1) clear_n++;
            @(negedge clk);
        end
        $display("move inst=%0d dir=%0d -> pos=(%0d,%0d) busy_cycles=%0d clear=%0d lock=%0b",
                 inst, d, prow[inst], pcol[inst], busy_n, clear_n, lock_o[inst]);
    endtask

    task automatic test_reset();
        pulse_rst();
        n_checks++; if (prow[0] !== 6'd1) begin n_fail++; $display("FAIL reset_row got=%0d exp=1", prow[0]); end
        n_checks++; if (pcol[0] !== 6'd1) begin n_fail++; $display("FAIL reset_col got=%0d exp=1", pcol[0]); end
        n_checks++; if (if_a.map_row !== 6'd1 || if_a.map_col !== 6'd1) begin n_fail++; $display("FAIL reset_map got=(%0d,%0d) exp=(1,1)", if_a.map_row, if_a.map_col); end
        n_checks++; if (lock_o[0] !== 1'b1 || key_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_flags got lock=%b key=%b exp lock=1 key=0", lock_o[0], key_o[0]); end
        n_checks++; if (busy_o[0] !== 1'b0 || clr_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got busy=%b clear=%b exp 0/0", busy_o[0], clr_o[0]); end
        // Reset in the middle of a move discards it.
        wall_a[1][2] = 1'b0;
        @(negedge clk);
        req[0] = 1'b1; dir[0] = 2'd3;
        @(negedge clk);
        req[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_o[0] !== 1'b0 || pcol[0] !== 6'd1) begin n_fail++; $display("FAIL reset_mid got busy=%b col=%0d exp busy=0 col=1", busy_o[0], pcol[0]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_commit_cooldown();
        int cnt;
        pulse_rst();
        wall_a[1][2] = 1'b0;
        wall_a[1][3] = 1'b0;
        @(negedge clk);
        req[0] = 1'b1; dir[0] = 2'd3;
        @(negedge clk);
        req[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k < 2) begin
                n_checks++; if (if_a.map_col !== 6'd2 || pcol[0] !== 6'd1) begin n_fail++; $display("FAIL commit_addr k=%0d got map_col=%0d col=%0d exp 2/1", k, if_a.map_col, pcol[0]); end
            end
            if (k == 2) begin
                n_checks++; if (pcol[0] !== 6'd2) begin n_fail++; $display("FAIL commit_pos got col=%0d exp=2", pcol[0]); end
                req[0] = 1'b1; dir[0] = 2'd3;
            end
            if (k == 3) req[0] = 1'b0;
            if (busy_o[0] !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        req[0] = 1'b0;
        n_checks++; if (cnt !== 6) begin n_fail++; $display("FAIL commit_busy got=%0d exp=6", cnt); end
        repeat (3) @(negedge clk);
        n_checks++; if (pcol[0] !== 6'd2 || busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL cooldown_drop got col=%0d busy=%b exp col=2 busy=0", pcol[0], busy_o[0]); end
    endtask

    task automatic test_wall_reject();
        int b, cl;
        pulse_rst();
        wall_a[0][1] = 1'b1;
        do_move(0, 2'd0, b, cl);
        n_checks++; if (b !== 2) begin n_fail++; $display("FAIL wall_busy got=%0d exp=2", b); end
        n_checks++; if (prow[0] !== 6'd1 || pcol[0] !== 6'd1) begin n_fail++; $display("FAIL wall_pos got=(%0d,%0d) exp=(1,1)", prow[0], pcol[0]); end
    endtask

    task automatic test_out_of_bounds();
        int b, cl;
        pulse_rst();
        @(negedge clk);
        req[1] = 1'b1; dir[1] = 2'd3;
        @(negedge clk);
        req[1] = 1'b0;
        n_checks++; if (if_b.map_col !== 6'd40 || busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL oob_noquery got map_col=%0d busy=%b exp 40/0", if_b.map_col, busy_o[1]); end
        do_move(1, 2'd3, b, cl);
        n_checks++; if (b !== 0 || prow[1] !== 6'd20 || pcol[1] !== 6'd40) begin n_fail++; $display("FAIL oob_pos got busy=%0d pos=(%0d,%0d) exp 0 (20,40)", b, prow[1], pcol[1]); end
        // Inactive game state: request ignored, position held.
        st[1] = 4'd0;
        do_move(1, 2'd2, b, cl);
        n_checks++; if (b !== 0 || pcol[1] !== 6'd40) begin n_fail++; $display("FAIL inactive got busy=%0d col=%0d exp 0/40", b, pcol[1]); end
        st[1] = 4'd2;
    endtask

    task automatic test_lock_sequence();
        int b, cl;
        pulse_rst();
        do_move(2, 2'd3, b, cl);
        n_checks++; if (b !== 2 || pcol[2] !== 6'd39 || lock_o[2] !== 1'b1) begin n_fail++; $display("FAIL locked_exit got busy=%0d col=%0d lock=%b exp 2/39/1", b, pcol[2], lock_o[2]); end
        do_move(2, 2'd2, b, cl);
        n_checks++; if (pcol[2] !== 6'd38 || key_o[2] !== 1'b1 || lock_o[2] !== 1'b0) begin n_fail++; $display("FAIL key_pickup got col=%0d key=%b lock=%b exp 38/1/0", pcol[2], key_o[2], lock_o[2]); end
        do_move(2, 2'd3, b, cl);
        n_checks++; if (pcol[2] !== 6'd39 || cl !== 0) begin n_fail++; $display("FAIL step_back got col=%0d clear=%0d exp 39/0", pcol[2], cl); end
        do_move(2, 2'd3, b, cl);
        n_checks++; if (prow[2] !== 6'd20 || pcol[2] !== 6'd40 || b !== 6) begin n_fail++; $display("FAIL exit_pos got=(%0d,%0d) busy=%0d exp (20,40) 6", prow[2], pcol[2], b); end
        n_checks++; if (cl !== 1) begin n_fail++; $display("FAIL stage_clear got pulses=%0d exp=1", cl); end
    endtask

    task automatic test_stage_change();
        pulse_rst();
        @(negedge clk);
        req[2] = 1'b1; dir[2] = 2'd2;
        @(negedge clk);
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (key_o[2] !== 1'b1 || busy_o[2] !== 1'b1) begin n_fail++; $display("FAIL stage_pre got key=%b busy=%b exp 1/1", key_o[2], busy_o[2]); end
        st[2] = 4'd4; req[2] = 1'b1; dir[2] = 2'd1;
        @(negedge clk);
        req[2] = 1'b0;
        n_checks++; if (prow[2] !== 6'd20 || pcol[2] !== 6'd39) begin n_fail++; $display("FAIL stage_pos got=(%0d,%0d) exp=(20,39)", prow[2], pcol[2]); end
        n_checks++; if (lock_o[2] !== 1'b1 || key_o[2] !== 1'b0 || busy_o[2] !== 1'b0) begin n_fail++; $display("FAIL stage_flags got lock=%b key=%b busy=%b exp 1/0/0", lock_o[2], key_o[2], busy_o[2]); end
        @(negedge clk);
        n_checks++; if (busy_o[2] !== 1'b0 || prow[2] !== 6'd20) begin n_fail++; $display("FAIL stage_req_ignored got busy=%b row=%0d exp 0/20", busy_o[2], prow[2]); end
        st[2] = 4'd2;
    endtask

    // Random walk on the default instance against a rule-level model.
    task automatic test_random_walk();
        int r = 1, c = 1, tr, tc, eb, ec, b, cl;
        bit locked = 1'b1;
        for (int rr = 0; rr < 41; rr++)
            for (int cc = 0; cc < 41; cc++)
                wall_a[rr][cc] = ($urandom_range(0, 3) == 0);
        pulse_rst();
        for (int n = 0; n < 60; n++) begin
            logic [1:0] d;
            d  = 2'($urandom_range(0, 3));
            tr = r + (d == 2'd1 ? 1 : 0) - (d == 2'd0 ? 1 : 0);
            tc = c + (d == 2'd3 ? 1 : 0) - (d == 2'd2 ? 1 : 0);
            ec = 0;
            if (tr < 0 || tr > 40 || tc < 0 || tc > 40) eb = 0;
            else if (wall_a[tr][tc]) eb = 2;
            else if (tc == 40 && tr >= 19 && tr <= 21 && locked) eb = 2;
            else begin
                eb = 6;
                r = tr; c = tc;
                if (r == 37 && c == 1) locked = 1'b0;
                if (c == 40 && r >= 19 && r <= 21) ec = 1;
            end
            do_move(0, d, b, cl);
            n_checks++; if (b !== eb) begin n_fail++; $display("FAIL rand_busy n=%0d got=%0d exp=%0d", n, b, eb); end
            n_checks++; if (prow[0] !== 6'(r) || pcol[0] !== 6'(c)) begin n_fail++; $display("FAIL rand_pos n=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, prow[0], pcol[0], r, c); end
            n_checks++; if (lock_o[0] !== locked || cl !== ec) begin n_fail++; $display("FAIL rand_flags n=%0d got lock=%b clear=%0d exp %b/%0d", n, lock_o[0], cl, locked, ec); end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            dir[i] = 2'd0;
            st[i]  = 4'd2;
        end
        for (int rr = 0; rr < 64; rr++)
            for (int cc = 0; cc < 64; cc++)
                wall_a[rr][cc] = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_commit_cooldown();
        test_wall_reject();
        test_out_of_bounds();
        test_lock_sequence();
        test_stage_change();
        test_random_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end
endmodule
